// File: rtl/wide_add_seq_if.sv
// ---------------------------------------------------------------------------
// wide_add_seq_if : start/busy/done handshake and operand/result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wide_add_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/wide_add_seq.sv
// ---------------------------------------------------------------------------
// wide_add_seq : byte-serial multi-precision add/subtract through one 8-bit slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wide_add_seq_slice8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = 9'(a_i) + 9'(b_i) + 9'(c_i);
endmodule

module wide_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wide_add_seq_if.slave bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = $clog2(NBYTES);
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
      $error("wide_add_seq: WIDTH must be a multiple of 8 and at least 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]       a_byte_d;
  logic [7:0]       b_byte_d;
  logic [7:0]       slice_sum_d;
  logic             slice_cout_d;

  assign a_byte_d = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte_d = b_q[{idx_q, 3'b000} +: 8];

  wide_add_seq_slice8 u_slice (
    .a_i (a_byte_d),
    .b_i (b_byte_d),
    .c_i (carry_q),
    .s_o (slice_sum_d),
    .c_o (slice_cout_d)
  );

  // b is stored pre-inverted in subtract mode, so the overflow rule below is the
  // plain same-sign-inputs / different-sign-result test for both modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          sum_q[{idx_q, 3'b000} +: 8] <= slice_sum_d;
          carry_q                     <= slice_cout_d;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            cout_q  <= slice_cout_d;
            ovf_q   <= (a_q[MSB] == b_q[MSB]) && (slice_sum_d[7] != a_q[MSB]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub | bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_wide_add_seq : directed + random checks of wide_add_seq against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wide_add_seq;
  localparam int WIDTH = 32;
  localparam longint SMAX  = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN  = -SMAX - 1;
  localparam longint TWO32 = 64'sh0000_0001_0000_0000;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  wide_add_seq_if #(.WIDTH(WIDTH)) bus_if ();

  wide_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, cout, sum} from signed/unsigned integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic s);
    longint ux, uy, ures, sx, sy, sres;
    logic   co, ov;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = $signed(x);
    sy = $signed(y);
    if (s) begin
      ures = ux - uy;
      co   = (ux >= uy);
      sres = sx - sy;
    end else begin
      ures = ux + uy + (ci ? 1 : 0);
      co   = (ures >= TWO32);
      sres = sx + sy + (ci ? 1 : 0);
    end
    ov = (sres > SMAX) || (sres < SMIN);
    return {ov, co, ures[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic tci, input logic ts);
    bus_if.start = 1'b1;
    bus_if.a     = ta;
    bus_if.b     = tb_v;
    bus_if.cin   = tci;
    bus_if.sub   = ts;
  endtask

  task automatic scramble_inputs();
    bus_if.start = 1'b0;
    bus_if.a     = $urandom;
    bus_if.b     = $urandom;
    bus_if.cin   = 1'($urandom);
    bus_if.sub   = 1'($urandom);
  endtask

  task automatic check_result(input string tag, input logic [33:0] e);
    check({tag, "/sum"},  64'(bus_if.sum),      64'(e[31:0]));
    check({tag, "/cout"}, 64'(bus_if.cout),     64'(e[32]));
    check({tag, "/ovf"},  64'(bus_if.overflow), 64'(e[33]));
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tci, input logic ts, input string tag);
    logic [33:0] e;
    int n;
    int busy_cyc;
    e = model(ta, tb_v, tci, ts);
    drive_start(ta, tb_v, tci, ts);
    tick();
    scramble_inputs();
    busy_cyc = (bus_if.busy === 1'b1) ? 1 : 0;
    n = 0;
    while (bus_if.done !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (bus_if.busy === 1'b1) busy_cyc++;
    end
    check({tag, "/latency"}, 64'(n), 64'd4);
    check_result(tag, e);
    tick();
    check({tag, "/busy_cycles"}, 64'(busy_cyc), 64'd5);
    check({tag, "/idle_done"}, 64'({bus_if.busy, bus_if.done}), 64'd0);
    check({tag, "/hold_sum"}, 64'(bus_if.sum), 64'(e[31:0]));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus_if.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [33:0] e1, e2;
    int n, n2;
    int busy_drop, saw_done;
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    bus_if.cin = 1'b0;
    bus_if.sub = 1'b0;

    repeat (3) tick();
    check("reset/busy", 64'(bus_if.busy), 64'd0);
    check("reset/done", 64'(bus_if.done), 64'd0);
    check("reset/sum",  64'(bus_if.sum),  64'd0);
    check("reset/cout", 64'(bus_if.cout), 64'd0);
    check("reset/ovf",  64'(bus_if.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "ripple");
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "chain_cin");
    do_op(32'd5, 32'd7, 1'b1, 1'b1, "sub_borrow");
    do_op(32'd7, 32'd5, 1'b0, 1'b1, "sub_noborrow");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf_add");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "ovf_sub");

    // start during RUN is ignored
    e1 = model(32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0);
    drive_start(32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0);
    tick();
    scramble_inputs();
    tick();
    drive_start(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1);
    tick();
    scramble_inputs();
    wait_done(n);
    check("run_start/latency", 64'(n), 64'd2);
    check_result("run_start", e1);
    tick();
    check("run_start/idle", 64'(bus_if.busy), 64'd0);

    // back-to-back acceptance in the DONE cycle
    e1 = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    e2 = model(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    drive_start(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    tick();
    scramble_inputs();
    wait_done(n);
    check("b2b/lat1", 64'(n), 64'd4);
    check_result("b2b/op1", e1);
    drive_start(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    tick();
    scramble_inputs();
    check("b2b/accept", 64'({bus_if.busy, bus_if.done}), 64'b10);
    check("b2b/cleared", 64'(bus_if.sum), 64'd0);
    n2 = 0;
    busy_drop = 0;
    while (bus_if.done !== 1'b1 && n2 < 20) begin
      tick();
      n2++;
      if (bus_if.busy !== 1'b1) busy_drop++;
    end
    check("b2b/gap", 64'(n2 + 1), 64'd5);
    check("b2b/no_idle", 64'(busy_drop), 64'd0);
    check_result("b2b/op2", e2);
    tick();

    // asynchronous reset mid-run
    drive_start(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    scramble_inputs();
    tick();
    tick();
    check("rst_mid/partial", 64'(bus_if.sum), 64'h0000_6789);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/busy", 64'(bus_if.busy), 64'd0);
    check("rst_mid/done", 64'(bus_if.done), 64'd0);
    check("rst_mid/sum",  64'(bus_if.sum),  64'd0);
    check("rst_mid/flags", 64'({bus_if.cout, bus_if.overflow}), 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (6) begin
      tick();
      if (bus_if.done === 1'b1) saw_done++;
    end
    check("rst_mid/no_done", 64'(saw_done), 64'd0);
    do_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i == 0) begin
        ra = 32'h8000_0000;
        rb = 32'h8000_0000;
        rs = 1'b0;
      end
      do_op(ra, rb, rc, rs, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
